// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Frogger round sequencer. Takes the collision checker's death/win flags and
// decides when frog and cars may move, tracks lives and levels, runs the
// post-death and post-win pause timers, requests frog respawns and ends the
// game when the last life is lost.
//
// Ports
//   clk              system clock
//   rst_n            synchronous active-low reset
//   frame_tick       one-cycle pulse per video frame
//   start_btn        debounced start button (level; rising edge starts a game)
//   death_collision  frog overlaps a car
//   win_collision    frog reached the top row
//   move_en          frog/car positions may update this frame
//   frog_respawn     one-cycle pulse: frog mover reloads its start position
//   lives [1:0]      remaining lives
//   level [3:0]      levels cleared, saturating at MAX_LEVEL
//   game_over        high while in GAME_OVER
//   state [2:0]      IDLE=0 PLAY=1 DYING=2 WIN=3 GAME_OVER=4
// -----------------------------------------------------------------------------
module game_controller #(
    parameter int START_LIVES  = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int WIN_FRAMES   = 30,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       death_collision,
    input  logic       win_collision,
    output logic       move_en,
    output logic       frog_respawn,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DYING = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WIN_LOAD   = 8'(WIN_FRAMES - 1);

    state_t     state_r, state_n;
    logic [1:0] lives_n;
    logic [3:0] level_n;
    logic [7:0] timer_r, timer_n;
    logic       guard_r, guard_n;
    logic       respawn_n;
    logic       start_q;
    logic       start_rise;

    // start_q follows the button even while reset is asserted, so a button
    // held through reset is seen as already pressed and must be released and
    // pressed again before a game starts.
    always_ff @(posedge clk) begin
        start_q <= start_btn;
    end

    assign start_rise = start_btn & ~start_q;

    always_comb begin
        state_n   = state_r;
        lives_n   = lives;
        level_n   = level;
        timer_n   = timer_r;
        guard_n   = guard_r;
        respawn_n = 1'b0;
        case (state_r)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_n   = S_PLAY;
                    lives_n   = LIVES_INIT;
                    level_n   = 4'd0;
                    timer_n   = 8'd0;
                    respawn_n = 1'b1;
                    guard_n   = 1'b1;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    // First tick after a respawn: frog position is stale, so
                    // collisions are discarded and the guard is dropped.
                    if (guard_r) begin
                        guard_n = 1'b0;
                    end else if (death_collision) begin
                        if (lives > 2'd1) begin
                            lives_n = lives - 2'd1;
                            timer_n = DEATH_LOAD;
                            state_n = S_DYING;
                        end else begin
                            lives_n = 2'd0;
                            state_n = S_OVER;
                        end
                    end else if (win_collision) begin
                        level_n = (level >= LEVEL_MAX) ? LEVEL_MAX : level + 4'd1;
                        timer_n = WIN_LOAD;
                        state_n = S_WIN;
                    end
                end
            end
            S_DYING, S_WIN: begin
                // Timer loaded with FRAMES-1; the tick seen at zero resumes
                // play, giving exactly FRAMES ticks of pause.
                if (frame_tick) begin
                    if (timer_r != 8'd0) begin
                        timer_n = timer_r - 8'd1;
                    end else begin
                        state_n   = S_PLAY;
                        respawn_n = 1'b1;
                        guard_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            lives        <= LIVES_INIT;
            level        <= 4'd0;
            timer_r      <= 8'd0;
            guard_r      <= 1'b0;
            move_en      <= 1'b0;
            frog_respawn <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_r      <= state_n;
            lives        <= lives_n;
            level        <= level_n;
            timer_r      <= timer_n;
            guard_r      <= guard_n;
            move_en      <= (state_n == S_PLAY);
            frog_respawn <= respawn_n;
            game_over    <= (state_n == S_OVER);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Drives game_controller with a directed game sequence followed by random
// play, and compares every output each cycle against a behavioural model of
// the round rules kept in this file.
// -----------------------------------------------------------------------------
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       death_collision = 1'b0;
    logic       win_collision = 1'b0;
    logic       move_en;
    logic       frog_respawn;
    logic [1:0] lives;
    logic [3:0] level;
    logic       game_over;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    game_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .start_btn       (start_btn),
        .death_collision (death_collision),
        .win_collision   (win_collision),
        .move_en         (move_en),
        .frog_respawn    (frog_respawn),
        .lives           (lives),
        .level           (level),
        .game_over       (game_over),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game phases: 0 idle, 1 playing, 2 dying, 3 won, 4 game over.
    // pause_left counts the frame ticks still to wait before play resumes.
    int m_state = 0, m_lives = 3, m_level = 0, pause_left = 0;
    bit m_respawn = 0, fresh_spawn = 0, prev_btn = 0, model_ok = 0;

    always @(posedge clk) begin
        bit pressed;
        pressed   = start_btn && !prev_btn;
        prev_btn  = start_btn;
        m_respawn = 0;
        if (!rst_n) begin
            m_state = 0; m_lives = 3; m_level = 0; pause_left = 0;
            fresh_spawn = 0; model_ok = 1;
        end else if (m_state == 0 || m_state == 4) begin
            if (pressed) begin
                m_state = 1; m_lives = 3; m_level = 0;
                m_respawn = 1; fresh_spawn = 1;
            end
        end else if (m_state == 1) begin
            if (frame_tick) begin
                if (fresh_spawn) fresh_spawn = 0;
                else if (death_collision) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = 4;
                    else begin m_state = 2; pause_left = 60; end
                end else if (win_collision) begin
                    m_level = (m_level + 1 > 9) ? 9 : m_level + 1;
                    m_state = 3; pause_left = 30;
                end
            end
        end else begin
            if (frame_tick) begin
                pause_left = pause_left - 1;
                if (pause_left == 0) begin
                    m_state = 1; m_respawn = 1; fresh_spawn = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            chk("state", int'(state), m_state);
            chk("lives", int'(lives), m_lives);
            chk("level", int'(level), m_level);
            chk("move_en", int'(move_en), int'(m_state == 1));
            chk("frog_respawn", int'(frog_respawn), int'(m_respawn));
            chk("game_over", int'(game_over), int'(m_state == 4));
        end
    end

    task automatic step(input logic t, input logic d, input logic w, input logic s);
        frame_tick = t; death_collision = d; win_collision = w; start_btn = s;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk("lit_reset_state", int'(state), 0);
        chk("lit_reset_lives", int'(lives), 3);
        chk("lit_reset_move", int'(move_en), 0);

        // Start
        step(0, 0, 0, 1);
        chk("lit_start_state", int'(state), 1);
        chk("lit_start_respawn", int'(frog_respawn), 1);
        chk("lit_start_move", int'(move_en), 1);
        step(0, 0, 0, 1);
        chk("lit_respawn_1cycle", int'(frog_respawn), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);                    // press while playing: ignored
        chk("lit_start_in_play", int'(frog_respawn), 0);

        // Guard tick, then first death
        step(1, 1, 0, 0);
        chk("lit_guard_state", int'(state), 1);
        step(1, 1, 0, 0);
        chk("lit_death_state", int'(state), 2);
        chk("lit_death_lives", int'(lives), 2);
        chk("lit_death_move", int'(move_en), 0);
        ticks(59);
        chk("lit_pause59", int'(state), 2);
        ticks(1);
        chk("lit_pause60_state", int'(state), 1);
        chk("lit_pause60_respawn", int'(frog_respawn), 1);
        step(1, 1, 0, 0);
        chk("lit_guard2_lives", int'(lives), 2);

        // Collisions without a tick are ignored; death beats win
        step(0, 1, 1, 0);
        chk("lit_notick", int'(state), 1);
        step(1, 1, 1, 0);
        chk("lit_both_state", int'(state), 2);
        chk("lit_both_lives", int'(lives), 1);
        chk("lit_both_level", int'(level), 0);
        ticks(60);
        step(1, 0, 0, 0);                    // guard tick
        step(1, 1, 0, 0);
        chk("lit_over_state", int'(state), 4);
        chk("lit_over_flag", int'(game_over), 1);
        chk("lit_over_lives", int'(lives), 0);

        // Restart from game over, then ten wins
        step(0, 0, 0, 1);
        chk("lit_restart_state", int'(state), 1);
        chk("lit_restart_lives", int'(lives), 3);
        step(1, 0, 0, 0);                    // guard tick
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            chk("lit_win_state", int'(state), 3);
            chk("lit_win_level", int'(level), (i + 1 > 9) ? 9 : i + 1);
            ticks(30);
            chk("lit_win_resume", int'(frog_respawn), 1);
            step(1, 0, 0, 0);                // guard tick
        end

        // Reset in the middle of a death pause, button held through reset
        step(1, 1, 0, 0);
        ticks(39);                           // timer now at 20
        rst_n = 1'b0;
        step(0, 0, 0, 1);
        chk("lit_midreset_state", int'(state), 0);
        chk("lit_midreset_lives", int'(lives), 3);
        chk("lit_midreset_level", int'(level), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("lit_held_btn", int'(state), 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("lit_repress", int'(state), 1);

        // Random play
        for (int c = 0; c < 20000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            death_collision = ($urandom_range(0, 11) == 0);
            win_collision = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
